// File: rtl/seven_seg_scanner_if.sv
// Bus bundle for seven_seg_scanner: value/strobe inputs and the segment/anode pin outputs.
// SEG_BLINK_EN adds the blink_mask signal.
interface seven_seg_scanner_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] data;
   logic                    load;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    enable;
   logic                    lzs;
`ifdef SEG_BLINK_EN
   logic [NUM_DIGITS-1:0]   blink_mask;
`endif
   logic [6:0]              seg;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_done;

`ifdef SEG_BLINK_EN
   modport master (output data, load, dp_in, enable, lzs, blink_mask,
                   input  seg, dp_n, an, frame_done);
   modport slave  (input  data, load, dp_in, enable, lzs, blink_mask,
                   output seg, dp_n, an, frame_done);
`else
   modport master (output data, load, dp_in, enable, lzs,
                   input  seg, dp_n, an, frame_done);
   modport slave  (input  data, load, dp_in, enable, lzs,
                   output seg, dp_n, an, frame_done);
`endif
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous double buffering,
// leading-zero suppression and per-digit decimal points. Optional blinking via SEG_BLINK_EN.
module seven_seg_scanner #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000
`ifdef SEG_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES = 64
`endif
) (
   input logic               CLK,
   input logic               RSTN,
   seven_seg_scanner_if.slave bus
);

   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [6:0] hex_decode(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0011000;
         4'hA: s = 7'b0100000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000100;
         4'hF: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                    pend_q, pend_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    fd_q, fd_d;

   logic       tick, wrap, blank, blink_blank, hi_zero;
   logic [3:0] nib;

   assign tick = (cnt_q == CntW'(SCAN_DIV - 1));
   assign wrap = tick && (idx_q == IdxW'(NUM_DIGITS - 1));

`ifdef SEG_BLINK_EN
   localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FcW-1:0] fcnt_q, fcnt_d;
   logic           blink_q, blink_d;

   always_comb begin
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (wrap) begin
         if (fcnt_q == FcW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         fcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         blink_q <= blink_d;
      end
   end

   assign blink_blank = blink_q && bus.blink_mask[idx_q];
`else
   assign blink_blank = 1'b0;
`endif

   // Digit k is a leading zero when nibble k and every nibble above it are zero.
   always_comb begin
      nib     = act_data_q[{idx_q, 2'b00} +: 4];
      hi_zero = ((act_data_q >> {idx_q, 2'b00}) == '0);
      blank   = !bus.enable || (bus.lzs && (idx_q != '0) && hi_zero) || blink_blank;
   end

   always_comb begin
      cnt_d       = tick ? '0 : cnt_q + 1'b1;
      idx_d       = idx_q;
      seg_d       = seg_q;
      dp_n_d      = dp_n_q;
      an_d        = an_q;
      fd_d        = wrap;
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      pend_d      = pend_q;

      if (tick) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
         if (blank) begin
            an_d   = '1;
            seg_d  = 7'h7F;
            dp_n_d = 1'b1;
         end else begin
            an_d   = ~(NUM_DIGITS'(1) << idx_q);
            seg_d  = hex_decode(nib);
            dp_n_d = ~act_dp_q[idx_q];
         end
      end

      // A load landing on the commit edge bypasses the pending buffer.
      if (wrap) begin
         if (bus.load) begin
            act_data_d = bus.data;
            act_dp_d   = bus.dp_in;
         end else if (pend_q) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
         end
         pend_d = 1'b0;
      end else if (bus.load) begin
         pend_data_d = bus.data;
         pend_dp_d   = bus.dp_in;
         pend_d      = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         pend_q      <= 1'b0;
         seg_q       <= 7'h7F;
         dp_n_q      <= 1'b1;
         an_q        <= '1;
         fd_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         act_data_q  <= act_data_d;
         act_dp_q    <= act_dp_d;
         pend_data_q <= pend_data_d;
         pend_dp_q   <= pend_dp_d;
         pend_q      <= pend_d;
         seg_q       <= seg_d;
         dp_n_q      <= dp_n_d;
         an_q        <= an_d;
         fd_q        <= fd_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp_n       = dp_n_q;
   assign bus.an         = an_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle-level reference model queues expected pin
// values each clock; a monitor pops and compares them. Honours SEG_BLINK_EN when defined.
module tb_seven_seg_scanner;
   localparam int unsigned N = 4;
   localparam int unsigned S = 4;
`ifdef SEG_BLINK_EN
   localparam int unsigned BF = 2;
`endif

   localparam logic [6:0] SegTab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
      7'b1111000, 7'b0000000, 7'b0011000, 7'b0100000, 7'b0000011, 7'b1000110, 7'b0100001,
      7'b0000100, 7'b0001110};

   typedef struct packed {
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         dp_n;
      logic         fd;
   } out_t;

   logic CLK = 1'b0;
   logic RSTN = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   out_t sb[$];

   seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

   seven_seg_scanner #(
      .NUM_DIGITS(N),
      .SCAN_DIV(S)
`ifdef SEG_BLINK_EN
      ,
      .BLINK_FRAMES(BF)
`endif
   ) dut (
      .CLK(CLK),
      .RSTN(RSTN),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   // Reference model: slot number and digit follow from counting clock edges since reset.
   initial begin
      int unsigned edges, ticks, frames, d;
      logic [15:0] act_v, pend_v;
      logic [3:0]  act_dp, pend_dp;
      bit          pend, wrap_e, blank;
      out_t        cur;
      edges = 0; ticks = 0; frames = 0;
      act_v = '0; pend_v = '0; act_dp = '0; pend_dp = '0; pend = 0;
      cur = '{an: '1, seg: 7'h7F, dp_n: 1'b1, fd: 1'b0};
      forever begin
         @(posedge CLK or negedge RSTN);
         if (!RSTN) begin
            edges = 0; ticks = 0; frames = 0;
            act_v = '0; pend_v = '0; act_dp = '0; pend_dp = '0; pend = 0;
            cur = '{an: '1, seg: 7'h7F, dp_n: 1'b1, fd: 1'b0};
            sb.delete();
         end else begin
            edges++;
            wrap_e = 0;
            cur.fd = 1'b0;
            if (edges % S == 0) begin
               d = ticks % N;
               ticks++;
               wrap_e = (d == N - 1);
               blank = !bus.enable || (bus.lzs && d != 0 && (act_v >> (4 * d)) == 0);
`ifdef SEG_BLINK_EN
               if (((frames / BF) % 2) == 1 && bus.blink_mask[d]) blank = 1;
`endif
               if (blank) begin
                  cur.an = '1; cur.seg = 7'h7F; cur.dp_n = 1'b1;
               end else begin
                  cur.an = '1;
                  cur.an[d] = 1'b0;
                  cur.seg = SegTab[4'(act_v >> (4 * d))];
                  cur.dp_n = !act_dp[d];
               end
               if (wrap_e) begin
                  cur.fd = 1'b1;
                  frames++;
               end
            end
            if (wrap_e) begin
               if (bus.load) begin
                  act_v = bus.data; act_dp = bus.dp_in;
               end else if (pend) begin
                  act_v = pend_v; act_dp = pend_dp;
               end
               pend = 0;
            end else if (bus.load) begin
               pend_v = bus.data; pend_dp = bus.dp_in; pend = 1;
            end
            sb.push_back(cur);
         end
      end
   end

   // Monitor: the registered outputs are presented every clock; pop and compare.
   initial begin
      out_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (RSTN) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_empty t=%0t got an=%b seg=%b, no expected entry",
                        $time, bus.an, bus.seg);
            end else begin
               e = sb.pop_front();
               if (bus.an !== e.an || bus.seg !== e.seg || bus.dp_n !== e.dp_n ||
                   bus.frame_done !== e.fd) begin
                  n_fail++;
                  $display("FAIL outputs t=%0t got an=%b seg=%b dp_n=%b fd=%b exp an=%b seg=%b dp_n=%b fd=%b",
                           $time, bus.an, bus.seg, bus.dp_n, bus.frame_done,
                           e.an, e.seg, e.dp_n, e.fd);
               end
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      bus.load  = 1'b1;
      bus.data  = v;
      bus.dp_in = dp;
      @(negedge CLK);
      bus.load  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.dp_n !== 1'b1 ||
          bus.frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s got an=%b seg=%b dp_n=%b fd=%b exp an=1111 seg=1111111 dp_n=1 fd=0",
                  name, bus.an, bus.seg, bus.dp_n, bus.frame_done);
      end
   endtask

   task automatic wait_fd();
      int k = 0;
      do begin
         @(posedge CLK);
         #1;
         k++;
      end while (bus.frame_done !== 1'b1 && k < 100);
      if (bus.frame_done !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_frame_done got no pulse within %0d cycles, required one", k);
      end
   endtask

   initial begin
      logic [15:0] v;
      bus.data = '0; bus.load = 1'b0; bus.dp_in = '0; bus.enable = 1'b1; bus.lzs = 1'b0;
`ifdef SEG_BLINK_EN
      bus.blink_mask = '0;
`endif
      cycles(2);
      #1;
      check_reset_outputs("reset_state");
      @(negedge CLK);
      RSTN = 1'b1;

      // Basic scan with one decimal point.
      do_load(16'h12AB, 4'b0100);
      cycles(60);

      // Leading-zero suppression.
      bus.lzs = 1'b1;
      do_load(16'h0050, 4'b0100);
      cycles(40);
      do_load(16'h0000, 4'b0000);
      cycles(40);
      bus.lzs = 1'b0;

      // Load mid-frame must not tear the current frame.
      do_load(16'h2222, 4'b0000);
      cycles(40);
      wait_fd();
      cycles(6);
      do_load(16'h1111, 4'b0001);
      cycles(40);

      // Pending load followed by a load on the exact commit edge.
      wait_fd();
      cycles(2);
      do_load(16'h4444, 4'b1111);
      cycles(13);
      do_load(16'h3333, 4'b0010);
      cycles(40);

      // Blanking while the scan keeps running.
      cycles(5);
      bus.enable = 1'b0;
      cycles(40);
      bus.enable = 1'b1;
      cycles(20);

      // Asynchronous reset mid-slot.
      cycles(1);
      #2;
      RSTN = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      cycles(2);
      RSTN = 1'b1;
      cycles(40);

      // Randomised traffic.
      for (int i = 0; i < 800; i++) begin
         @(negedge CLK);
         bus.load = ($urandom_range(7) == 0);
         if (bus.load) begin
            v = 16'($urandom);
            for (int j = 0; j < N; j++) if ($urandom_range(1) == 1) v[4*j +: 4] = 4'h0;
            bus.data  = v;
            bus.dp_in = N'($urandom);
         end
         if ($urandom_range(31) == 0) bus.enable = ~bus.enable;
         if ($urandom_range(31) == 0) bus.lzs = ~bus.lzs;
`ifdef SEG_BLINK_EN
         if ($urandom_range(63) == 0) bus.blink_mask = N'($urandom);
`endif
      end
      @(negedge CLK);
      bus.load = 1'b0; bus.enable = 1'b1; bus.lzs = 1'b0;

`ifdef SEG_BLINK_EN
      bus.blink_mask = 4'b0001;
      do_load(16'h1234, 4'b0000);
      cycles(200);
`endif
      cycles(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout, required completion before 1 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
